// File: rtl/lea128_key_sched_ctrl_if.sv
// Round-key stream interface between the LEA-128 key schedule controller
// and the encryption round core.
//   rk_valid : round key presented
//   rk_ready : consumer accepts the presented round key this cycle
//   rk       : 192-bit round key {T1,T3,T1,T2,T1,T0}
//   rk_idx   : round index of the presented key
// master = key schedule controller, slave = round core.
interface lea128_key_sched_ctrl_if;
    logic         rk_valid;
    logic         rk_ready;
    logic [191:0] rk;
    logic [4:0]   rk_idx;

    modport master (output rk_valid, output rk, output rk_idx, input rk_ready);
    modport slave  (input rk_valid, input rk, input rk_idx, output rk_ready);
endinterface

// File: rtl/lea128_key_sched_ctrl.sv
// LEA-128 key schedule controller. A single shared round datapath updates
// T0..T3 once per round and streams each 192-bit round key over a
// valid/ready handshake.
//
// Ports:
//   clk, rst_n : clock (rising edge), async active-low reset
//   start      : one-cycle pulse, loads key and starts (honoured in IDLE only)
//   key        : 128-bit key, K0 = key[31:0] .. K3 = key[127:96]
//   abort      : synchronous abort back to IDLE, beats start and handshake
//   rk_bus     : round-key stream (master side)
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse when the last round key is accepted
//
// Optional build macro: LEA_KEY_ZEROIZE_EN
//   When defined, T0..T3 and the rk register are cleared on done/abort and
//   rk reads zero whenever rk_valid is low.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start
// LOAD    | key latched into T0..T3, one cycle to absorb key fan-in
// CALC    | apply delta-add-rotate for round i, capture round key
// PRESENT | round key i valid, held until rk_ready
module lea128_key_sched_ctrl #(
    parameter int          NROUNDS = 24,
    parameter logic [31:0] DELTA0  = 32'hc3efe9db,
    parameter logic [31:0] DELTA1  = 32'h44626b02,
    parameter logic [31:0] DELTA2  = 32'h79e27c8a,
    parameter logic [31:0] DELTA3  = 32'h78df30ec
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [127:0]                   key,
    input  logic                           abort,
    lea128_key_sched_ctrl_if.master        rk_bus,
    output logic                           busy,
    output logic                           done
);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, PRESENT} state_t;

    localparam logic [4:0] LAST_IDX = 5'(NROUNDS - 1);

    state_t       state;
    logic [31:0]  t0, t1, t2, t3;
    logic [4:0]   idx;
    logic [191:0] rk_q;
    logic         valid_q;
    logic         busy_q;
    logic         done_q;

    logic [31:0]  delta;
    logic [31:0]  t0_n, t1_n, t2_n, t3_n;

    // Rotate left; {x,x} shifted keeps the wrapped bits in the upper half.
    function automatic logic [31:0] rol(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] w;
        w = {x, x} << n;
        return w[63:32];
    endfunction

    always_comb begin
        delta = DELTA0;
        case (idx[1:0])
            2'd0: delta = DELTA0;
            2'd1: delta = DELTA1;
            2'd2: delta = DELTA2;
            2'd3: delta = DELTA3;
        endcase
    end

    // idx never exceeds 23, so idx+3 fits in 5 bits and the 5-bit width
    // gives the mod-32 rotate amount for free.
    assign t0_n = rol(t0 + rol(delta, idx),         5'd1);
    assign t1_n = rol(t1 + rol(delta, idx + 5'd1),  5'd3);
    assign t2_n = rol(t2 + rol(delta, idx + 5'd2),  5'd6);
    assign t3_n = rol(t3 + rol(delta, idx + 5'd3),  5'd11);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            t0      <= '0;
            t1      <= '0;
            t2      <= '0;
            t3      <= '0;
            idx     <= '0;
            rk_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                idx     <= '0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
`ifdef LEA_KEY_ZEROIZE_EN
                t0      <= '0;
                t1      <= '0;
                t2      <= '0;
                t3      <= '0;
                rk_q    <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            t0     <= key[31:0];
                            t1     <= key[63:32];
                            t2     <= key[95:64];
                            t3     <= key[127:96];
                            idx    <= '0;
                            busy_q <= 1'b1;
                            state  <= LOAD;
                        end
                    end
                    LOAD: begin
                        state <= CALC;
                    end
                    CALC: begin
                        t0      <= t0_n;
                        t1      <= t1_n;
                        t2      <= t2_n;
                        t3      <= t3_n;
                        rk_q    <= {t1_n, t3_n, t1_n, t2_n, t1_n, t0_n};
                        valid_q <= 1'b1;
                        state   <= PRESENT;
                    end
                    PRESENT: begin
                        // rk_valid is always high here, so rk_ready alone
                        // completes the handshake.
                        if (rk_bus.rk_ready) begin
                            valid_q <= 1'b0;
`ifdef LEA_KEY_ZEROIZE_EN
                            rk_q    <= '0;
`endif
                            if (idx == LAST_IDX) begin
                                idx    <= '0;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                state  <= IDLE;
`ifdef LEA_KEY_ZEROIZE_EN
                                t0     <= '0;
                                t1     <= '0;
                                t2     <= '0;
                                t3     <= '0;
`endif
                            end else begin
                                idx   <= idx + 5'd1;
                                state <= CALC;
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rk_bus.rk_valid = valid_q;
    assign rk_bus.rk       = rk_q;
    assign rk_bus.rk_idx   = idx;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_lea128_key_sched_ctrl.sv
module tb_lea128_key_sched_ctrl;
    localparam int NR = 24;
    localparam logic [127:0] KEY1 = 128'hf0e1d2c3_b4a59687_78695a4b_3c2d1e0f;
    localparam logic [127:0] KEY2 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [127:0] key;
    logic         busy;
    logic         done;

    lea128_key_sched_ctrl_if rk_if ();

    lea128_key_sched_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .key    (key),
        .abort  (abort),
        .rk_bus (rk_if.master),
        .busy   (busy),
        .done   (done)
    );

    int total = 0;
    int bad   = 0;
    int exp_idx = 0;
    bit model_on = 1'b0;
    logic [191:0] model_rk [NR];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        int m;
        m = n % 32;
        if (m == 0) return x;
        return (x << m) | (x >> (32 - m));
    endfunction

    // Software key schedule straight from the algorithm definition.
    task automatic build_model(input logic [127:0] k);
        logic [31:0] t [4];
        logic [31:0] d [4];
        int sh [4];
        d[0] = 32'hc3efe9db; d[1] = 32'h44626b02;
        d[2] = 32'h79e27c8a; d[3] = 32'h78df30ec;
        sh[0] = 1; sh[1] = 3; sh[2] = 6; sh[3] = 11;
        for (int j = 0; j < 4; j++) t[j] = k[32*j +: 32];
        for (int i = 0; i < NR; i++) begin
            for (int j = 0; j < 4; j++) t[j] = rol(t[j] + rol(d[i % 4], i + j), sh[j]);
            model_rk[i] = {t[1], t[3], t[1], t[2], t[1], t[0]};
        end
    endtask

    // Stream checker: every presented key must be the next one of the schedule.
    always @(negedge clk) begin
        if (model_on && rst_n) begin
            if (rk_if.rk_valid) begin
                check("stream_busy", busy, 1'b1);
                if (exp_idx < NR) begin
                    check("stream_idx", rk_if.rk_idx, exp_idx);
                    check("stream_rk", rk_if.rk, model_rk[exp_idx]);
                end else begin
                    check("stream_overrun", exp_idx, NR - 1);
                end
                if (rk_if.rk_ready) exp_idx++;
            end else begin
`ifdef LEA_KEY_ZEROIZE_EN
                check("zero_rk_when_invalid", rk_if.rk, '0);
`endif
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] k);
        key = k;
        build_model(k);
        exp_idx = 0;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_idx(input int n, input string name);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (rk_if.rk_valid && rk_if.rk_idx == 5'(n)) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        check(name, found, 1'b1);
    endtask

    task automatic wait_done(input string name);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        check(name, found, 1'b1);
    endtask

    task automatic check_rk0(input string pfx);
        check({pfx, "_valid"}, rk_if.rk_valid, 1'b1);
        check({pfx, "_idx"}, rk_if.rk_idx, 5'd0);
        check({pfx, "_w0"}, rk_if.rk[31:0], 32'h003a0fd4);
        check({pfx, "_w1"}, rk_if.rk[63:32], 32'h02497010);
        check({pfx, "_w3"}, rk_if.rk[127:96], 32'h02497010);
        check({pfx, "_w5"}, rk_if.rk[191:160], 32'h02497010);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        int done_cnt;
        int done_cyc;
        logic [191:0] held;

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        key   = '0;
        rk_if.rk_ready = 1'b0;

        // Pin the model with hand-computed RK0 words.
        build_model(KEY1);
        check("model_rk0_w0", model_rk[0][31:0], 32'h003a0fd4);
        check("model_rk0_w1", model_rk[0][63:32], 32'h02497010);

        cyc(); cyc();
        check("rst_valid", rk_if.rk_valid, 1'b0);
        check("rst_rk", rk_if.rk, '0);
        check("rst_idx", rk_if.rk_idx, 5'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        #2 rst_n = 1'b1;
        cyc();
        model_on = 1'b1;

        // RK0 latency and value, then full schedule with ready held high.
        rk_if.rk_ready = 1'b1;
        do_start(KEY1);
        check("lat_c1_valid", rk_if.rk_valid, 1'b0);
        check("lat_c1_busy", busy, 1'b1);
        cyc();
        check("lat_c2_valid", rk_if.rk_valid, 1'b0);
        cyc();
        check_rk0("rk0");

        hs = 0; done_cnt = 0; done_cyc = -1;
        for (int c = 3; c <= 60; c++) begin
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                check("done_busy_low", busy, 1'b0);
            end
            if (rk_if.rk_valid && rk_if.rk_ready) hs++;
            cyc();
        end
        check("full_handshakes", hs, NR);
        check("full_done_count", done_cnt, 1);
        check("full_done_cycle", done_cyc, 50);
        check("full_exp_idx", exp_idx, NR);
`ifdef LEA_KEY_ZEROIZE_EN
        check("zeroize_rk", rk_if.rk, '0);
        check("zeroize_t", {dut.t0, dut.t1, dut.t2, dut.t3}, '0);
`else
        check("retain_rk23", rk_if.rk, model_rk[NR-1]);
`endif

        // Backpressure at round 5.
        do_start(KEY1);
        wait_idx(5, "wait_round5");
        rk_if.rk_ready = 1'b0;
        held = rk_if.rk;
        for (int c = 0; c < 7; c++) begin
            cyc();
            check("bp_valid", rk_if.rk_valid, 1'b1);
            check("bp_idx", rk_if.rk_idx, 5'd5);
            check("bp_rk", rk_if.rk, held);
        end
        rk_if.rk_ready = 1'b1;
        cyc();
        check("bp_gap_valid", rk_if.rk_valid, 1'b0);
        cyc();
        check("bp_r6_valid", rk_if.rk_valid, 1'b1);
        check("bp_r6_idx", rk_if.rk_idx, 5'd6);
        check("bp_r6_rk", rk_if.rk, model_rk[6]);
        wait_done("bp_done");
        cyc();

        // start while busy is ignored, abort at round 12.
        do_start(KEY1);
        wait_idx(10, "wait_round10");
        key = KEY2;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("start_ignored_busy", busy, 1'b1);
        key = KEY1;
        wait_idx(12, "wait_round12");
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_valid", rk_if.rk_valid, 1'b0);
        check("abort_done", done, 1'b0);
        for (int c = 0; c < 4; c++) begin
            cyc();
            check("abort_no_done", done, 1'b0);
        end
        do_start(KEY1);
        cyc(); cyc();
        check_rk0("abort_restart");
        wait_done("abort_restart_done");
        cyc();

        // Asynchronous reset at round 17 with a second key.
        do_start(KEY2);
        wait_idx(17, "wait_round17");
        #2;
        rst_n = 1'b0;
        model_on = 1'b0;
        #1;
        check("arst_valid", rk_if.rk_valid, 1'b0);
        check("arst_rk", rk_if.rk, '0);
        check("arst_idx", rk_if.rk_idx, 5'd0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        cyc();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            check("arst_no_done", done, 1'b0);
        end
        model_on = 1'b1;
        do_start(KEY1);
        cyc(); cyc();
        check_rk0("arst_restart");
        wait_done("arst_restart_done");
        cyc();

        // Full run with the second key, checked by the stream checker.
        do_start(KEY2);
        wait_done("key2_done");
        check("key2_exp_idx", exp_idx, NR);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
